// File: rtl/rc4_keystream_gen_if.sv
// Key-load and keystream handshake bundle between the key source / cipher stage
// (master) and the RC4 generator (slave).
interface rc4_keystream_gen_if #(
  parameter int KLW = 5
);
  logic           start;
  logic [KLW-1:0] key_len;
  logic           key_valid;
  logic           key_ready;
  logic [7:0]     key_byte;
  logic           ks_valid;
  logic           ks_ready;
  logic [7:0]     ks_data;
  logic           busy;
  logic           cfg_err;

  modport master (
    output start, key_len, key_valid, key_byte, ks_ready,
    input  key_ready, ks_valid, ks_data, busy, cfg_err
  );

  modport slave (
    input  start, key_len, key_valid, key_byte, ks_ready,
    output key_ready, ks_valid, ks_data, busy, cfg_err
  );
endinterface

// File: rtl/rc4_keystream_gen.sv
// RC4 keystream generator: key load, 256-cycle S init, 512-cycle KSA, then one byte
// per 3 clocks with drop-DISCARD; output held in HOLD until the consumer takes it.
module rc4_keystream_gen #(
  parameter int KEY_LEN_MAX = 16,
  parameter int DISCARD     = 1536
) (
  input  logic               clk,
  input  logic               rst,
  rc4_keystream_gen_if.slave ks_if
);
  localparam int KLW = $clog2(KEY_LEN_MAX + 1);
  localparam int KIW = (KEY_LEN_MAX > 1) ? $clog2(KEY_LEN_MAX) : 1;
  localparam int DW  = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_KEYLOAD, ST_INIT, ST_KSA_A, ST_KSA_B, ST_GEN1, ST_GEN2, ST_GEN3, ST_HOLD
  } state_e;

  state_e         state_q, state_d;
  logic [7:0]     i_q, i_d, j_q, j_d;
  logic [KIW-1:0] k_q, k_d;
  logic [KLW-1:0] klen_q, klen_d;
  logic [DW-1:0]  disc_q, disc_d;
  logic           ks_valid_q, ks_valid_d;
  logic [7:0]     ks_data_q, ks_data_d;
  logic           cfg_err_q, cfg_err_d;

  logic [7:0] s_q [256];
  logic [7:0] key_q [KEY_LEN_MAX];
  logic       s_we0, s_we1, key_we;
  logic [7:0] s_a0, s_d0, s_a1, s_d1;

  logic [7:0] si, sj, t_idx, gen_byte;
  logic       k_last, len_bad;

  assign si     = s_q[i_q];
  assign sj     = s_q[j_q];
  assign t_idx  = si + sj;
  // Output byte is read from S after the swap this cycle commits.
  assign gen_byte = (t_idx == i_q) ? sj : (t_idx == j_q) ? si : s_q[t_idx];
  assign k_last  = (KLW'(k_q) == klen_q - 1'b1);
  assign len_bad = (ks_if.key_len == '0) || (ks_if.key_len > KLW'(KEY_LEN_MAX));

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    klen_d     = klen_q;
    disc_d     = disc_q;
    ks_valid_d = ks_valid_q;
    ks_data_d  = ks_data_q;
    cfg_err_d  = 1'b0;
    s_we0      = 1'b0;
    s_we1      = 1'b0;
    s_a0       = i_q;
    s_d0       = sj;
    s_a1       = j_q;
    s_d1       = si;
    key_we     = 1'b0;
    if (ks_if.start) begin
      ks_valid_d = 1'b0;
      i_d        = '0;
      j_d        = '0;
      k_d        = '0;
      disc_d     = '0;
      if (len_bad) begin
        cfg_err_d = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        klen_d  = ks_if.key_len;
        state_d = ST_KEYLOAD;
      end
    end else begin
      unique case (state_q)
        ST_KEYLOAD: if (ks_if.key_valid) begin
          key_we = 1'b1;
          if (k_last) begin
            k_d     = '0;
            state_d = ST_INIT;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        ST_INIT: begin
          s_we0 = 1'b1;
          s_d0  = i_q;
          i_d   = i_q + 8'd1;
          if (i_q == 8'hFF) begin
            j_d     = '0;
            state_d = ST_KSA_A;
          end
        end
        ST_KSA_A: begin
          j_d     = j_q + si + key_q[k_q];
          state_d = ST_KSA_B;
        end
        ST_KSA_B: begin
          s_we0 = 1'b1;
          s_we1 = 1'b1;
          if (i_q == 8'hFF) begin
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            state_d = ST_GEN1;
          end else begin
            i_d     = i_q + 8'd1;
            k_d     = k_last ? '0 : k_q + 1'b1;
            state_d = ST_KSA_A;
          end
        end
        ST_GEN1: begin
          i_d     = i_q + 8'd1;
          state_d = ST_GEN2;
        end
        ST_GEN2: begin
          j_d     = j_q + si;
          state_d = ST_GEN3;
        end
        ST_GEN3: begin
          s_we0 = 1'b1;
          s_we1 = 1'b1;
          if (disc_q != DW'(DISCARD)) begin
            disc_d  = disc_q + 1'b1;
            state_d = ST_GEN1;
          end else begin
            ks_data_d  = gen_byte;
            ks_valid_d = 1'b1;
            state_d    = ST_HOLD;
          end
        end
        // A transfer doubles as the GEN1 step so the stream keeps a 3-clock cadence.
        ST_HOLD: if (ks_if.ks_ready) begin
          ks_valid_d = 1'b0;
          i_d        = i_q + 8'd1;
          state_d    = ST_GEN2;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      klen_q     <= '0;
      disc_q     <= '0;
      ks_valid_q <= 1'b0;
      ks_data_q  <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      klen_q     <= klen_d;
      disc_q     <= disc_d;
      ks_valid_q <= ks_valid_d;
      ks_data_q  <= ks_data_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (s_we0) s_q[s_a0] <= s_d0;
    if (s_we1) s_q[s_a1] <= s_d1;
    if (key_we) key_q[k_q] <= ks_if.key_byte;
  end

  assign ks_if.key_ready = (state_q == ST_KEYLOAD);
  assign ks_if.busy      = (state_q != ST_IDLE);
  assign ks_if.ks_valid  = ks_valid_q;
  assign ks_if.ks_data   = ks_data_q;
  assign ks_if.cfg_err   = cfg_err_q;
endmodule
